// File: rtl/async_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : async_fifo_pkg
// Purpose  : Shared definitions for the async_fifo block:
//            - default DATA_WIDTH / ADDR_WIDTH values
//            - ptr_t : ADDR_WIDTH+1 bit pointer (MSB = wrap bit)
//            - ptr_full / ptr_empty : occupancy decode from two pointers
// Macro    : ASYNC_FIFO_ERR_FLAGS_EN (used by the interface and top, not here)
// Revision : 1.0 - initial release
// ============================================================================
package async_fifo_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ADDR_WIDTH = 4;
   localparam int DEF_DEPTH      = 1 << DEF_ADDR_WIDTH;

   typedef logic [DEF_ADDR_WIDTH:0] ptr_t;

   // Full: same slot, but the writer has lapped the reader once.
   function automatic logic ptr_full(input ptr_t wptr, input ptr_t rptr);
      return (wptr[DEF_ADDR_WIDTH-1:0] == rptr[DEF_ADDR_WIDTH-1:0]) &&
             (wptr[DEF_ADDR_WIDTH] != rptr[DEF_ADDR_WIDTH]);
   endfunction

   function automatic logic ptr_empty(input ptr_t wptr, input ptr_t rptr);
      return (wptr == rptr);
   endfunction

endpackage : async_fifo_pkg
`default_nettype wire

// File: rtl/async_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : async_fifo_if
// Purpose  : Producer/consumer handshake bundle for async_fifo.
//            master : drives write_en, read_en, data_in; observes status/data
//            slave  : the FIFO side
// Signals  : write_en, read_en, data_in[DATA_WIDTH], full, empty,
//            out[DATA_WIDTH]; overflow/underflow when
//            ASYNC_FIFO_ERR_FLAGS_EN is defined
// Revision : 1.0 - initial release
// ============================================================================
interface async_fifo_if
   import async_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
   logic                  write_en;
   logic                  read_en;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  full;
   logic                  empty;
   logic [DATA_WIDTH-1:0] out;
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
   logic                  overflow;
   logic                  underflow;

   modport master (output write_en, read_en, data_in,
                   input  full, empty, out, overflow, underflow);
   modport slave  (input  write_en, read_en, data_in,
                   output full, empty, out, overflow, underflow);
`else
   modport master (output write_en, read_en, data_in,
                   input  full, empty, out);
   modport slave  (input  write_en, read_en, data_in,
                   output full, empty, out);
`endif
endinterface : async_fifo_if
`default_nettype wire

// File: rtl/async_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : async_fifo_mem
// Purpose  : DEPTH x DATA_WIDTH register array, synchronous write port and a
//            registered read port. Only the read register is reset; the
//            array contents survive reset.
// Ports    : clk, reset (async, active-high)
//            wr_en_i, wr_addr_i, wr_data_i  - write port
//            rd_en_i, rd_addr_i             - read port
//            rd_data_o                      - registered read data
// Revision : 1.0 - initial release
// ============================================================================
module async_fifo_mem
   import async_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  wire logic                  clk,
   input  wire logic                  reset,
   input  wire logic                  wr_en_i,
   input  wire logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  wire logic [DATA_WIDTH-1:0] wr_data_i,
   input  wire logic                  rd_en_i,
   input  wire logic [ADDR_WIDTH-1:0] rd_addr_i,
   output logic      [DATA_WIDTH-1:0] rd_data_o
);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Holds its value between accepted reads.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data_q <= '0;
      end else if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule : async_fifo_mem
`default_nettype wire

// File: rtl/async_fifo.sv
`default_nettype none
// ============================================================================
// Module   : async_fifo
// Purpose  : Single-clock FIFO, DEPTH = 2**ADDR_WIDTH entries, registered
//            full/empty flags and registered read data.
// Ports    : clk   - clock, rising edge
//            reset - asynchronous, active-high
//            bus   - async_fifo_if.slave (write_en, read_en, data_in,
//                    full, empty, out [, overflow, underflow])
// Macro    : ASYNC_FIFO_ERR_FLAGS_EN - adds sticky overflow/underflow flags
// Revision : 1.0 - initial release
// ============================================================================
module async_fifo
   import async_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  wire logic     clk,
   input  wire logic     reset,
   async_fifo_if.slave   bus
);
   logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
   logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
   logic                  full_q, full_d;
   logic                  empty_q, empty_d;
   logic                  wr_acc;
   logic                  rd_acc;
   logic [DATA_WIDTH-1:0] rd_data;

   // Acceptance uses the registered flags, so a write arriving while full is
   // dropped even if a read frees a slot on the same edge.
   assign wr_acc = bus.write_en & ~full_q;
   assign rd_acc = bus.read_en  & ~empty_q;

   assign wptr_d = wptr_q + {{ADDR_WIDTH{1'b0}}, wr_acc};
   assign rptr_d = rptr_q + {{ADDR_WIDTH{1'b0}}, rd_acc};

   // Flags are decoded from the next pointers and registered, so they move
   // on the same edge as the pointers.
   generate
      if (ADDR_WIDTH == DEF_ADDR_WIDTH) begin : g_pkg_flags
         assign full_d  = ptr_full(wptr_d, rptr_d);
         assign empty_d = ptr_empty(wptr_d, rptr_d);
      end else begin : g_generic_flags
         assign full_d  = (wptr_d[ADDR_WIDTH-1:0] == rptr_d[ADDR_WIDTH-1:0]) &&
                          (wptr_d[ADDR_WIDTH] != rptr_d[ADDR_WIDTH]);
         assign empty_d = (wptr_d == rptr_d);
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         full_q  <= full_d;
         empty_q <= empty_d;
      end
   end

   async_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk       (clk),
      .reset     (reset),
      .wr_en_i   (wr_acc),
      .wr_addr_i (wptr_q[ADDR_WIDTH-1:0]),
      .wr_data_i (bus.data_in),
      .rd_en_i   (rd_acc),
      .rd_addr_i (rptr_q[ADDR_WIDTH-1:0]),
      .rd_data_o (rd_data)
   );

   assign bus.full  = full_q;
   assign bus.empty = empty_q;
   assign bus.out   = rd_data;

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
   logic overflow_q;
   logic underflow_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (bus.write_en && full_q) begin
            overflow_q <= 1'b1;
         end
         if (bus.read_en && empty_q) begin
            underflow_q <= 1'b1;
         end
      end
   end

   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;
`endif

endmodule : async_fifo
`default_nettype wire

// File: tb/tb_async_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_async_fifo
// Purpose  : Self-checking bench for async_fifo. A reference occupancy count
//            and a queue of accepted write data predict full/empty/out and
//            (when ASYNC_FIFO_ERR_FLAGS_EN is defined) overflow/underflow.
// Revision : 1.0 - initial release
// ============================================================================
module tb_async_fifo;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 1 << AW;

   logic clk;
   logic reset;

   async_fifo_if #(.DATA_WIDTH(DW)) bus ();

   async_fifo #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_cmp;
   int          n_err;
   logic [7:0]  sb_q[$];
   int          cnt;
   logic [7:0]  exp_out;
   logic        exp_ovf;
   logic        exp_unf;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag);
      chk({tag, ".out"},   {24'd0, bus.out}, {24'd0, exp_out});
      chk({tag, ".empty"}, {31'd0, bus.empty}, {31'd0, (cnt == 0)});
      chk({tag, ".full"},  {31'd0, bus.full},  {31'd0, (cnt == DEPTH)});
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
      chk({tag, ".overflow"},  {31'd0, bus.overflow},  {31'd0, exp_ovf});
      chk({tag, ".underflow"}, {31'd0, bus.underflow}, {31'd0, exp_unf});
`endif
   endtask

   // One clock cycle of stimulus; the model predicts from the state before
   // the edge, then the DUT is sampled 1 time unit after the edge.
   task automatic step(input string tag, input logic we, input logic re, input logic [7:0] d);
      logic wacc;
      logic racc;
      wacc = we && (cnt < DEPTH);
      racc = re && (cnt > 0);
      if (we && cnt == DEPTH) exp_ovf = 1'b1;
      if (re && cnt == 0)     exp_unf = 1'b1;
      bus.write_en = we;
      bus.read_en  = re;
      bus.data_in  = d;
      @(posedge clk);
      #1;
      if (racc) exp_out = sb_q.pop_front();
      if (wacc) sb_q.push_back(d);
      cnt = cnt + (wacc ? 1 : 0) - (racc ? 1 : 0);
      bus.write_en = 1'b0;
      bus.read_en  = 1'b0;
      chk_state(tag);
   endtask

   task automatic model_reset();
      sb_q.delete();
      cnt     = 0;
      exp_out = 8'h00;
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
   endtask

   // Reset asserted between edges; outputs must clear without a clock edge.
   task automatic pulse_reset(input string tag);
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      chk_state(tag);
      @(negedge clk);
      reset = 1'b0;
      #1;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      bus.write_en = 1'b0;
      bus.read_en  = 1'b0;
      bus.data_in  = '0;
      reset        = 1'b1;
      model_reset();
      #1;
      chk_state("por");
      @(negedge clk);
      reset = 1'b0;

      // Single write then read.
      step("wr24", 1'b1, 1'b0, 8'h24);
      step("rd24", 1'b0, 1'b1, 8'h00);

      // Ordering, plus a read on empty that must be ignored.
      step("ord_w0", 1'b1, 1'b0, 8'h24);
      step("ord_w1", 1'b1, 1'b0, 8'h81);
      step("ord_w2", 1'b1, 1'b0, 8'h09);
      for (int i = 0; i < 4; i++) step("ord_rd", 1'b0, 1'b1, 8'h00);

      // Simultaneous write/read while empty: only the write lands.
      step("empty_wr_rd", 1'b1, 1'b1, 8'h3C);
      step("empty_wr_rd_drain", 1'b0, 1'b1, 8'h00);

      pulse_reset("rst_a");

      // Fill, overflow attempt, drain.
      for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 1'b0, 8'(i));
      step("ovf_wr", 1'b1, 1'b0, 8'hAA);
      for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 1'b1, 8'h00);
      step("unf_rd", 1'b0, 1'b1, 8'h00);

      // Wrap-around and full-boundary concurrency.
      for (int i = 0; i < DEPTH; i++) step("wfill", 1'b1, 1'b0, 8'(i));
      for (int i = 0; i < 8; i++)     step("wrd8", 1'b0, 1'b1, 8'h00);
      for (int i = 0; i < 8; i++)     step("wwr8", 1'b1, 1'b0, 8'(8'h10 + i));
      step("full_wr_rd", 1'b1, 1'b1, 8'hEE);
      for (int i = 0; i < DEPTH - 1; i++) step("wdrain", 1'b0, 1'b1, 8'h00);
      step("wdrain_end", 1'b0, 1'b1, 8'h00);

      // Reset with 5 entries held, then a fresh write/read.
      for (int i = 0; i < 6; i++) step("mid_wr", 1'b1, 1'b0, 8'(8'h60 + i));
      step("mid_rd", 1'b0, 1'b1, 8'h00);
      pulse_reset("rst_mid");
      step("post_wr", 1'b1, 1'b0, 8'h5A);
      step("post_rd", 1'b0, 1'b1, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_async_fifo
`default_nettype wire
